bu_arbiter: RTL and testbench

- Round-robin, AHB-transfer-aware bus arbiter for the CPU bus-interface unit.
- Decides which of NREQ bus units (TLB walker, L1 refill/writeback, external master, ...) owns the shared AHB master port.
- Produces one-hot acks that drive the downstream address/control mux. It never switches the mux mid-transfer.
- A hold-time limit with a preempt handshake bounds how long any one requester can keep the bus.

---
 rtl/bu_arbiter.sv | 141 ++++++++++++++
 tb/tb_bu_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bu_arbiter.sv
// Round-robin AHB bus arbiter: grants one requester at a time, never switches
// mid-transfer, and can ask a long-running owner to yield via preempt_req.
`timescale 1ns/1ps
module bu_arbiter #(
  parameter int NREQ     = 3,
  parameter int HOLD_MAX = 64,
  parameter int IDW      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] bus_req,
  input  logic [NREQ-1:0] bus_lock,
  input  logic [1:0]      own_htrans,
  input  logic            hready,
  output logic [NREQ-1:0] bus_ack,
  output logic [IDW-1:0]  owner_id,
  output logic            bus_busy,
  output logic [NREQ-1:0] preempt_req
);

  localparam int              HW       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]   HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] bus_ack_reg, bus_ack_next;
  logic [IDW-1:0]  owner_id_reg, owner_id_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [NREQ-1:0] preempt_reg, preempt_next;
  logic            busy_reg, busy_next;

  logic [NREQ-1:0] other_req;
  logic            owner_req, owner_lock, force_rel;
  logic            pick_valid;
  logic [IDW-1:0]  pick_id, cand;
  logic [NREQ-1:0] pick_onehot;

  // bus_ack_reg doubles as the owner's one-hot mask while in OWN
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_other
      assign other_req[gi] = bus_req[gi] & ~bus_ack_reg[gi];
    end
  endgenerate

  assign owner_req  = |(bus_req & bus_ack_reg);
  assign owner_lock = |(bus_lock & bus_ack_reg);
  assign force_rel  = (|preempt_reg) && (own_htrans == 2'b00) && hready;

  // Scan rr_ptr+1, rr_ptr+2, ... with an explicit wrap so any NREQ works
  always_comb begin
    pick_valid  = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    cand        = rr_ptr_reg;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand >= LAST_ID) ? '0 : cand + IDW'(1);
      for (int j = 0; j < NREQ; j++) begin
        if (!pick_valid && (cand == IDW'(j)) && bus_req[j]) begin
          pick_valid     = 1'b1;
          pick_id        = cand;
          pick_onehot    = '0;
          pick_onehot[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus_ack_next  = bus_ack_reg;
    owner_id_next = owner_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    busy_next     = busy_reg;
    preempt_next  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next    = ST_OWN;
          bus_ack_next  = pick_onehot;
          owner_id_next = pick_id;
          hold_cnt_next = '0;
          busy_next     = 1'b1;
        end
      end
      ST_OWN: begin
        if (!owner_req || force_rel) begin
          state_next   = ST_DRAIN;
          bus_ack_next = '0;
        end else begin
          if (hold_cnt_reg != HOLD_LIM) hold_cnt_next = hold_cnt_reg + HW'(1);
          // Recomputed every cycle so a withdrawn request or new lock cancels it
          if ((HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LIM) && (|other_req) && !owner_lock)
            preempt_next = bus_ack_reg;
        end
      end
      ST_DRAIN: begin
        if (hready) begin
          state_next  = ST_IDLE;
          rr_ptr_next = owner_id_reg;
          busy_next   = 1'b0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        bus_ack_next = '0;
        busy_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      bus_ack_reg  <= '0;
      owner_id_reg <= '0;
      rr_ptr_reg   <= LAST_ID;
      hold_cnt_reg <= '0;
      preempt_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bus_ack_reg  <= bus_ack_next;
      owner_id_reg <= owner_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      preempt_reg  <= preempt_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus_ack     = bus_ack_reg;
  assign owner_id    = owner_id_reg;
  assign bus_busy    = busy_reg;
  assign preempt_req = preempt_reg;

endmodule

// File: tb/tb_bu_arbiter.sv
// Bench for bu_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=0) share stimulus
// and are compared against a cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_bu_arbiter;

  localparam int N = 3;

  logic       clk, rst_n;
  logic [2:0] req, lock;
  logic [1:0] htrans;
  logic       hready;
  logic [2:0] ack_p, pre_p, id_p, ack_n, pre_n, id_n;
  logic       busy_p, busy_n;

  int tests_run = 0;
  int tests_failed = 0;

  bu_arbiter #(.NREQ(3), .HOLD_MAX(4), .IDW(3)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .bus_req(req), .bus_lock(lock), .own_htrans(htrans),
    .hready(hready), .bus_ack(ack_p), .owner_id(id_p), .bus_busy(busy_p), .preempt_req(pre_p));

  bu_arbiter #(.NREQ(3), .HOLD_MAX(0), .IDW(3)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .bus_req(req), .bus_lock(lock), .own_htrans(htrans),
    .hready(hready), .bus_ack(ack_n), .owner_id(id_n), .bus_busy(busy_n), .preempt_req(pre_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 tracks HOLD_MAX=4, index 1 tracks HOLD_MAX=0.
  // phase: 0 = nobody owns, 1 = owned, 2 = last transfer's data phase
  int m_hold[2] = '{4, 0};
  int m_phase[2], m_owner[2], m_last[2], m_held[2];
  bit m_pre[2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_owner[m] = 0; m_last[m] = N - 1; m_held[m] = 0; m_pre[m] = 0;
    end
  endfunction

  function automatic void model_step(input logic [2:0] r, input logic [2:0] lk,
                                     input logic [1:0] ht, input logic hr);
    for (int m = 0; m < 2; m++) begin
      case (m_phase[m])
        0: if (r != 3'b000) begin
             bit found = 0;
             for (int k = 1; k <= N; k++) begin
               int c = (m_last[m] + k) % N;
               if (!found && r[c]) begin m_owner[m] = c; found = 1; end
             end
             m_phase[m] = 1; m_held[m] = 0; m_pre[m] = 0;
           end
        1: if (!r[m_owner[m]] || (m_pre[m] && ht == 2'b00 && hr)) begin
             m_phase[m] = 2; m_pre[m] = 0;
           end else begin
             bit others = (r & ~(3'b001 << m_owner[m])) != 3'b000;
             m_pre[m] = (m_hold[m] != 0) && (m_held[m] == m_hold[m]) && others && !lk[m_owner[m]];
             m_held[m] = (m_held[m] < m_hold[m]) ? m_held[m] + 1 : m_hold[m];
           end
        default: if (hr) begin m_last[m] = m_owner[m]; m_phase[m] = 0; end
      endcase
    end
  endfunction

  function automatic logic [2:0] exp_ack(int m);
    return (m_phase[m] == 1) ? 3'(3'b001 << m_owner[m]) : 3'b000;
  endfunction
  function automatic logic [2:0] exp_pre(int m);
    return m_pre[m] ? 3'(3'b001 << m_owner[m]) : 3'b000;
  endfunction

  // Inputs change on negedge; model advances on the posedge that samples them
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(req, lock, htrans, hready);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0; htrans = 2'b00; hready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (ack_p !== 3'b000) begin tests_failed++; $display("FAIL reset_ack: got %b want 000", ack_p); end
    tests_run++; if (busy_p !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_p); end
    tests_run++; if (pre_p !== 3'b000) begin tests_failed++; $display("FAIL reset_pre: got %b want 000", pre_p); end
    tests_run++; if (id_p !== 3'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", id_p); end
  endtask

  task automatic test_round_robin();
    logic [2:0] rq[3] = '{3'b110, 3'b101, 3'b011};
    logic [2:0] want[3] = '{3'b010, 3'b100, 3'b001};
    do_reset();
    req = 3'b111; htrans = 2'b10;
    tick();
    tests_run++; if (ack_p !== 3'b001) begin tests_failed++; $display("FAIL rr_first: got %b want 001", ack_p); end
    for (int i = 0; i < 3; i++) begin
      req = rq[i];
      tick();
      tests_run++; if ({ack_p, busy_p} !== 4'b0001) begin tests_failed++; $display("FAIL rr_drain%0d: ack/busy %b/%b want 000/1", i, ack_p, busy_p); end
      tick();
      tests_run++; if ({ack_p, busy_p} !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle%0d: ack/busy %b/%b want 000/0", i, ack_p, busy_p); end
      tick();
      tests_run++; if (ack_p !== want[i]) begin tests_failed++; $display("FAIL rr_grant%0d: got %b want %b", i, ack_p, want[i]); end
    end
  endtask

  task automatic test_drain_hold();
    do_reset();
    req = 3'b010; htrans = 2'b10;
    tick();
    tests_run++; if (ack_p !== 3'b010) begin tests_failed++; $display("FAIL dh_grant1: got %b want 010", ack_p); end
    req = 3'b101;
    tick();
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({ack_p, busy_p} !== 4'b0001) begin tests_failed++; $display("FAIL dh_wait%0d: ack/busy %b/%b want 000/1", i, ack_p, busy_p); end
    end
    hready = 1'b1;
    tick();
    tests_run++; if ({ack_p, busy_p} !== 4'b0000) begin tests_failed++; $display("FAIL dh_idle: ack/busy %b/%b want 000/0", ack_p, busy_p); end
    tick();
    tests_run++; if (ack_p !== 3'b100 || id_p !== 3'd2) begin tests_failed++; $display("FAIL dh_next: ack %b id %0d want 100 id 2", ack_p, id_p); end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 3'b001; htrans = 2'b10;
    tick();
    req = 3'b101;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++; if ({ack_p, pre_p} !== 6'b001_000) begin tests_failed++; $display("FAIL pe_early%0d: ack/pre %b/%b want 001/000", i, ack_p, pre_p); end
    end
    tick();
    tests_run++; if (pre_p !== 3'b001) begin tests_failed++; $display("FAIL pe_assert: got %b want 001", pre_p); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if ({ack_p, pre_p} !== 6'b001_001) begin tests_failed++; $display("FAIL pe_wait%0d: ack/pre %b/%b want 001/001", i, ack_p, pre_p); end
    end
    htrans = 2'b00;
    tick();
    tests_run++; if ({ack_p, busy_p} !== 4'b0001) begin tests_failed++; $display("FAIL pe_release: ack/busy %b/%b want 000/1", ack_p, busy_p); end
    tick();
    tick();
    tests_run++; if (ack_p !== 3'b100) begin tests_failed++; $display("FAIL pe_next: got %b want 100", ack_p); end
    tests_run++; if ({ack_n, pre_n} !== 6'b001_000) begin tests_failed++; $display("FAIL pe_hold0: ack/pre %b/%b want 001/000", ack_n, pre_n); end
  endtask

  task automatic test_lock();
    do_reset();
    lock = 3'b001; req = 3'b001; htrans = 2'b10;
    tick();
    req = 3'b101;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++; if ({ack_p, pre_p} !== 6'b001_000) begin tests_failed++; $display("FAIL lk_hold%0d: ack/pre %b/%b want 001/000", i, ack_p, pre_p); end
    end
    lock = 3'b000;
    tick();
    tests_run++; if (pre_p !== 3'b001) begin tests_failed++; $display("FAIL lk_unlock: got %b want 001", pre_p); end
    lock = 3'b001;
    tick();
    tests_run++; if ({ack_p, pre_p} !== 6'b001_000) begin tests_failed++; $display("FAIL lk_relock: ack/pre %b/%b want 001/000", ack_p, pre_p); end
  endtask

  task automatic test_idle_withdraw();
    do_reset();
    #1 req = 3'b010;
    #2 req = 3'b000;
    tick();
    tests_run++; if ({ack_p, busy_p} !== 4'b0000) begin tests_failed++; $display("FAIL iw_nogrant: ack/busy %b/%b want 000/0", ack_p, busy_p); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b011; htrans = 2'b10;
    tick();
    tests_run++; if (ack_p !== 3'b001) begin tests_failed++; $display("FAIL ar_own: got %b want 001", ack_p); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++; if ({ack_p, busy_p, ack_n, busy_n} !== 8'b0) begin tests_failed++; $display("FAIL ar_async: ack/busy %b/%b %b/%b want all 0", ack_p, busy_p, ack_n, busy_n); end
    @(negedge clk);
    rst_n = 1'b1; req = 3'b110;
    tick();
    tests_run++; if (ack_p !== 3'b010) begin tests_failed++; $display("FAIL ar_regrant: got %b want 010", ack_p); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 15) == 0) lock = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      htrans = 2'($urandom_range(0, 3));
      hready = ($urandom_range(0, 3) != 0);
      tick();
      tests_run++; if (ack_p !== exp_ack(0)) begin tests_failed++; $display("FAIL rnd_ack_p c%0d: got %b want %b", c, ack_p, exp_ack(0)); end
      tests_run++; if (pre_p !== exp_pre(0)) begin tests_failed++; $display("FAIL rnd_pre_p c%0d: got %b want %b", c, pre_p, exp_pre(0)); end
      tests_run++; if (id_p !== 3'(m_owner[0]) || busy_p !== (m_phase[0] != 0)) begin tests_failed++; $display("FAIL rnd_id_p c%0d: id/busy %0d/%b want %0d/%b", c, id_p, busy_p, m_owner[0], m_phase[0] != 0); end
      tests_run++; if (ack_n !== exp_ack(1)) begin tests_failed++; $display("FAIL rnd_ack_n c%0d: got %b want %b", c, ack_n, exp_ack(1)); end
      tests_run++; if (pre_n !== 3'b000) begin tests_failed++; $display("FAIL rnd_pre_n c%0d: got %b want 000", c, pre_n); end
      tests_run++; if (id_n !== 3'(m_owner[1]) || busy_n !== (m_phase[1] != 0)) begin tests_failed++; $display("FAIL rnd_id_n c%0d: id/busy %0d/%b want %0d/%b", c, id_n, busy_n, m_owner[1], m_phase[1] != 0); end
      tests_run++; if (!$onehot0(ack_p) || !$onehot0(ack_n)) begin tests_failed++; $display("FAIL rnd_onehot c%0d: acks %b %b not onehot0", c, ack_p, ack_n); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; htrans = 2'b00; hready = 1'b1;
    test_reset();
    test_round_robin();
    test_drain_hold();
    test_preempt();
    test_lock();
    test_idle_withdraw();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
